// File: rtl/mux_n_reg_if.sv
// ---------------------------------------------------------------------------
// mux_n_reg_if
//   Bundles the control, data and status signals of mux_n_reg so the mux
//   and its driver connect through a single port.
//
//   Parameters
//     WIDTH  data width of each input and of data_out
//     N_IN   number of data inputs; SEL_W = $clog2(N_IN)
//
//   Signals (direction seen from the mux, i.e. the slave modport)
//     sel_load    in   load sel_in into the selector register
//     sel_in      in   new selector value (SEL_W bits)
//     scan_en     in   advance the selector by one, wrapping at N_IN-1
//     data_in     in   packed inputs, input i = data_in[i*WIDTH +: WIDTH]
//     out_en      in   capture the selected input into data_out
//     data_out    out  registered mux output
//     data_valid  out  one-cycle strobe after each capture
//     sel_cur     out  current selector register value
//     sel_err     out  out-of-range load flag (only with MUXN_SEL_ERR_EN)
//
//   Optional feature macro: MUXN_SEL_ERR_EN
// ---------------------------------------------------------------------------
interface mux_n_reg_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 5
);
  localparam int SEL_W = $clog2(N_IN);

  logic                  sel_load;
  logic [SEL_W-1:0]      sel_in;
  logic                  scan_en;
  logic [N_IN*WIDTH-1:0] data_in;
  logic                  out_en;
  logic [WIDTH-1:0]      data_out;
  logic                  data_valid;
  logic [SEL_W-1:0]      sel_cur;
`ifdef MUXN_SEL_ERR_EN
  logic                  sel_err;
`endif

  // Driver side: produces control and data, observes the registered outputs.
  modport master (
    output sel_load, sel_in, scan_en, data_in, out_en,
    input  data_out, data_valid, sel_cur
`ifdef MUXN_SEL_ERR_EN
    , input sel_err
`endif
  );

  // Mux side.
  modport slave (
    input  sel_load, sel_in, scan_en, data_in, out_en,
    output data_out, data_valid, sel_cur
`ifdef MUXN_SEL_ERR_EN
    , output sel_err
`endif
  );
endinterface : mux_n_reg_if

// File: rtl/mux_n_reg.sv
// ---------------------------------------------------------------------------
// mux_n_reg
//   Registered N-input datapath multiplexer with a registered selector.
//   The selector is either loaded directly or auto-advanced in scan mode.
//   A capture always uses the selector value held before the capturing
//   edge, so control can pick a source one state ahead of the capture.
//
//   Parameters
//     WIDTH  data width (>=1)
//     N_IN   number of inputs (>=2); SEL_W = $clog2(N_IN) is derived
//
//   Ports
//     clk      rising-edge clock
//     reset    asynchronous, active-low reset
//     mux_if   mux_n_reg_if.slave: sel_load, sel_in, scan_en, data_in,
//              out_en in; data_out, data_valid, sel_cur (and sel_err) out
//
//   Optional feature macro: MUXN_SEL_ERR_EN
//     defined   : out-of-range loads keep the selector and pulse sel_err
//     undefined : out-of-range loads fall back to input 0, no sel_err
// ---------------------------------------------------------------------------
module mux_n_reg #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 5
) (
  input logic        clk,
  input logic        reset,
  mux_n_reg_if.slave mux_if
);

  localparam int               SEL_W    = $clog2(N_IN);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);
  // One extra bit so the range compare also works when N_IN == 2**SEL_W.
  localparam logic [SEL_W:0]   N_IN_EXT = (SEL_W + 1)'(N_IN);

  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
`ifdef MUXN_SEL_ERR_EN
  logic             err_q,   err_d;
`endif

  // Unpacked view of the packed input bus.
  logic [WIDTH-1:0] src [N_IN];

  for (genvar g = 0; g < N_IN; g++) begin : g_src
    assign src[g] = mux_if.data_in[g*WIDTH +: WIDTH];
  end

  logic             sel_in_ok;
  logic [SEL_W-1:0] sel_scan;

  assign sel_in_ok = ({1'b0, mux_if.sel_in} < N_IN_EXT);
  // Explicit wrap: for non-power-of-2 N_IN the unused codes are never reached.
  assign sel_scan  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

  // Selector next state: load has priority over scan, otherwise hold.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sel_d = sel_q;
`ifdef MUXN_SEL_ERR_EN
    err_d = 1'b0;
`endif
    if (mux_if.sel_load) begin
      if (sel_in_ok) begin
        sel_d = mux_if.sel_in;
      end else begin
`ifdef MUXN_SEL_ERR_EN
        err_d = 1'b1;
`else
        sel_d = '0;
`endif
      end
    end else if (mux_if.scan_en) begin
      sel_d = sel_scan;
    end
  end

  // Output register next state: reads sel_q (the pre-edge selector), so a
  // same-edge load or scan never affects the value being captured.
  always_comb begin
    data_d  = data_q;
    valid_d = mux_if.out_en;
    if (mux_if.out_en) begin
      data_d = src[sel_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef MUXN_SEL_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others regardless of statement order.
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef MUXN_SEL_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // All outputs come straight from registers.
  assign mux_if.data_out   = data_q;
  assign mux_if.data_valid = valid_q;
  assign mux_if.sel_cur    = sel_q;
`ifdef MUXN_SEL_ERR_EN
  assign mux_if.sel_err    = err_q;
`endif

endmodule : mux_n_reg

// File: tb/tb_mux_n_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_n_reg
//   Two instances: N_IN=5/WIDTH=32 and N_IN=8/WIDTH=8. Directed cycles push
//   the hand-computed captured value into a per-instance queue whenever
//   out_en is issued; a monitor on the falling edge pops and compares each
//   time data_valid is seen. Selector, reset and flag values are checked
//   directly one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mux_n_reg;

  logic clk;
  logic reset;

  int total = 0;
  int bad   = 0;

  logic [31:0] q5 [$];
  logic [7:0]  q8 [$];

  mux_n_reg_if #(.WIDTH(32), .N_IN(5)) b5 ();
  mux_n_reg_if #(.WIDTH(8),  .N_IN(8)) b8 ();

  mux_n_reg #(.WIDTH(32), .N_IN(5)) u5 (
    .clk    (clk),
    .reset  (reset),
    .mux_if (b5.slave)
  );

  mux_n_reg #(.WIDTH(8), .N_IN(8)) u8 (
    .clk    (clk),
    .reset  (reset),
    .mux_if (b8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one pop per observed strobe.
  always @(negedge clk) begin
    if (b5.data_valid === 1'b1) begin
      if (q5.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon5_extra_valid: got data %h expected no strobe (t=%0t)", b5.data_out, $time);
      end else begin
        check("mon5_data", b5.data_out, q5.pop_front());
      end
    end
    if (b8.data_valid === 1'b1) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon8_extra_valid: got data %h expected no strobe (t=%0t)", b8.data_out, $time);
      end else begin
        check("mon8_data", {24'h0, b8.data_out}, {24'h0, q8.pop_front()});
      end
    end
  end

  // One clock cycle on the 5-input instance; exp_d is only used when oe=1.
  task automatic cyc5(input logic ld, input logic [2:0] si, input logic sc,
                      input logic oe, input logic [31:0] exp_d, input logic [2:0] exp_sel);
    b5.sel_load = ld;
    b5.sel_in   = si;
    b5.scan_en  = sc;
    b5.out_en   = oe;
    if (oe) q5.push_back(exp_d);
    @(posedge clk);
    #1;
    check("sel5", {29'h0, b5.sel_cur}, {29'h0, exp_sel});
    b5.sel_load = 1'b0;
    b5.sel_in   = '0;
    b5.scan_en  = 1'b0;
    b5.out_en   = 1'b0;
  endtask

  task automatic cyc8(input logic ld, input logic [2:0] si, input logic sc,
                      input logic oe, input logic [7:0] exp_d, input logic [2:0] exp_sel);
    b8.sel_load = ld;
    b8.sel_in   = si;
    b8.scan_en  = sc;
    b8.out_en   = oe;
    if (oe) q8.push_back(exp_d);
    @(posedge clk);
    #1;
    check("sel8", {29'h0, b8.sel_cur}, {29'h0, exp_sel});
    b8.sel_load = 1'b0;
    b8.sel_in   = '0;
    b8.scan_en  = 1'b0;
    b8.out_en   = 1'b0;
  endtask

  logic [31:0] in0_5;
  logic [7:0]  in0_8;

  initial begin
    reset       = 1'b0;
    b5.sel_load = 1'b0; b5.sel_in = '0; b5.scan_en = 1'b0; b5.out_en = 1'b0;
    b8.sel_load = 1'b0; b8.sel_in = '0; b8.scan_en = 1'b0; b8.out_en = 1'b0;
    for (int i = 0; i < 5; i++) b5.data_in[i*32 +: 32] = $urandom();
    for (int i = 0; i < 8; i++) b8.data_in[i*8 +: 8] = 8'($urandom());
    in0_5 = b5.data_in[31:0];
    in0_8 = b8.data_in[7:0];

    // 1: reset state with random inputs and toggling controls.
    b5.out_en = 1'b1; b5.scan_en = 1'b1; b8.out_en = 1'b1; b8.scan_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b5.out_en = 1'b0; b5.scan_en = 1'b0; b8.out_en = 1'b0; b8.scan_en = 1'b0;
    check("rst5_data",  b5.data_out, 32'h0);
    check("rst5_valid", {31'h0, b5.data_valid}, 32'h0);
    check("rst5_sel",   {29'h0, b5.sel_cur}, 32'h0);
    check("rst8_data",  {24'h0, b8.data_out}, 32'h0);
    check("rst8_valid", {31'h0, b8.data_valid}, 32'h0);
    check("rst8_sel",   {29'h0, b8.sel_cur}, 32'h0);
`ifdef MUXN_SEL_ERR_EN
    check("rst5_err",   {31'h0, b5.sel_err}, 32'h0);
`endif
    reset = 1'b1;
    cyc5(1'b0, 3'd0, 1'b0, 1'b1, in0_5, 3'd0);
    cyc8(1'b0, 3'd0, 1'b0, 1'b1, in0_8, 3'd0);

    // 2: direct load then capture, N_IN=5.
    b5.data_in = {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b8.data_in = {8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    cyc5(1'b1, 3'd3, 1'b0, 1'b0, 32'h0,  3'd3);
    cyc5(1'b0, 3'd0, 1'b0, 1'b1, 32'hA3, 3'd3);
    check("valid5_high", {31'h0, b5.data_valid}, 32'h1);
    cyc5(1'b0, 3'd0, 1'b0, 1'b0, 32'h0,  3'd3);
    check("valid5_one_cycle", {31'h0, b5.data_valid}, 32'h0);
    check("hold5_data", b5.data_out, 32'hA3);
    // Input change without out_en must not reach data_out.
    b5.data_in = {5{32'hDEAD_BEEF}};
    cyc5(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 3'd3);
    check("hold5_data_in_change", b5.data_out, 32'hA3);
    b5.data_in = {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};

    // 3: scan wrap with same-edge capture of the old source.
    cyc5(1'b0, 3'd0, 1'b1, 1'b1, 32'hA3, 3'd4);
    cyc5(1'b0, 3'd0, 1'b1, 1'b1, 32'hA4, 3'd0);
    cyc5(1'b0, 3'd0, 1'b1, 1'b1, 32'hA0, 3'd1);

    // 4: load beats scan on the same edge; capture still uses the old source.
    cyc5(1'b1, 3'd3, 1'b0, 1'b0, 32'h0,  3'd3);
    cyc5(1'b1, 3'd1, 1'b1, 1'b1, 32'hA3, 3'd1);
    cyc5(1'b0, 3'd0, 1'b0, 1'b1, 32'hA1, 3'd1);

    // 5: out-of-range load from sel_cur=2.
    cyc5(1'b1, 3'd2, 1'b0, 1'b0, 32'h0, 3'd2);
`ifdef MUXN_SEL_ERR_EN
    cyc5(1'b1, 3'd6, 1'b0, 1'b0, 32'h0, 3'd2);
    check("err5_set", {31'h0, b5.sel_err}, 32'h1);
    cyc5(1'b0, 3'd0, 1'b0, 1'b1, 32'hA2, 3'd2);
    check("err5_clear", {31'h0, b5.sel_err}, 32'h0);
`else
    cyc5(1'b1, 3'd6, 1'b0, 1'b0, 32'h0, 3'd0);
    cyc5(1'b0, 3'd0, 1'b0, 1'b1, 32'hA0, 3'd0);
`endif
    cyc5(1'b1, 3'd7, 1'b0, 1'b0, 32'h0, 3'd0
`ifdef MUXN_SEL_ERR_EN
         + 3'd2
`endif
    );

    // 2-3 rerun on N_IN=8, WIDTH=8, plus natural overflow wrap 7 -> 0.
    cyc8(1'b1, 3'd3, 1'b0, 1'b0, 8'h0,  3'd3);
    cyc8(1'b0, 3'd0, 1'b0, 1'b1, 8'hA3, 3'd3);
    cyc8(1'b0, 3'd0, 1'b1, 1'b1, 8'hA3, 3'd4);
    cyc8(1'b0, 3'd0, 1'b1, 1'b1, 8'hA4, 3'd5);
    cyc8(1'b0, 3'd0, 1'b1, 1'b1, 8'hA5, 3'd6);
    check("valid8_high", {31'h0, b8.data_valid}, 32'h1);
    cyc8(1'b1, 3'd7, 1'b0, 1'b1, 8'hA6, 3'd7);
    cyc8(1'b0, 3'd0, 1'b1, 1'b1, 8'hA7, 3'd0);
    cyc8(1'b0, 3'd0, 1'b0, 1'b1, 8'hA0, 3'd0);
    cyc8(1'b0, 3'd0, 1'b0, 1'b0, 8'h0,  3'd0);
    check("valid8_one_cycle", {31'h0, b8.data_valid}, 32'h0);
    check("hold8_data", {24'h0, b8.data_out}, 32'hA0);

    // 6: async reset between edges while scanning and capturing.
    cyc5(1'b1, 3'd2, 1'b0, 1'b0, 32'h0,  3'd2);
    cyc5(1'b0, 3'd0, 1'b1, 1'b1, 32'hA2, 3'd3);
    cyc8(1'b1, 3'd5, 1'b0, 1'b1, 8'hA0,  3'd5);
    b5.scan_en = 1'b1; b5.out_en = 1'b1;
    b8.scan_en = 1'b1; b8.out_en = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("arst5_data",  b5.data_out, 32'h0);
    check("arst5_valid", {31'h0, b5.data_valid}, 32'h0);
    check("arst5_sel",   {29'h0, b5.sel_cur}, 32'h0);
    check("arst8_data",  {24'h0, b8.data_out}, 32'h0);
    check("arst8_sel",   {29'h0, b8.sel_cur}, 32'h0);
    @(posedge clk);
    #1;
    check("arst5_held", b5.data_out, 32'h0);
    b5.scan_en = 1'b0; b5.out_en = 1'b0;
    b8.scan_en = 1'b0; b8.out_en = 1'b0;
    reset = 1'b1;
    cyc5(1'b0, 3'd0, 1'b0, 1'b1, 32'hA0, 3'd0);
    cyc5(1'b0, 3'd0, 1'b0, 1'b0, 32'h0,  3'd0);
    @(negedge clk);
    #1;

    check("q5_drained", q5.size(), 32'h0);
    check("q8_drained", q8.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_n_reg
